lake_spec: RTL and testbench

- Configurable single-write/single-read on-chip buffer tile. Holds 16-bit words in a circular SRAM.
- Accepts a linear input stream on port_0.
- Replays it on port_1 in a 2-level affine address pattern, so data can be reused or reordered.
- Operates either on a fixed static schedule or under latency-insensitive ready/valid control. The whole configuration arrives as one flat bit vector.

---
 rtl/lake_spec_pkg.sv | 41 ++++
 rtl/lake_spec_addr_gen.sv | 60 ++++++
 rtl/lake_spec.sv | 152 +++++++++++++++
 tb/tb_lake_spec.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/lake_spec_pkg.sv
// Shared configuration layout for the lake_spec buffer tile: field offsets,
// the decoded configuration struct and the flat-vector decoder.
package lake_spec_pkg;

    localparam int CFG_USED_BITS  = 113;
    localparam int FIELD_W        = 16;

    localparam int RV_MODE_LSB    = 0;
    localparam int WR_COUNT_LSB   = 1;
    localparam int RD_START_LSB   = 17;
    localparam int RD_OFFSET_LSB  = 33;
    localparam int RD_EXTENT0_LSB = 49;
    localparam int RD_STRIDE0_LSB = 65;
    localparam int RD_EXTENT1_LSB = 81;
    localparam int RD_STRIDE1_LSB = 97;

    typedef struct packed {
        logic        rv_mode;
        logic [15:0] wr_count;
        logic [15:0] rd_start;
        logic [15:0] rd_offset;
        logic [15:0] rd_extent0;
        logic [15:0] rd_stride0;
        logic [15:0] rd_extent1;
        logic [15:0] rd_stride1;
    } cfg_t;

    function automatic cfg_t decode_cfg(input logic [CFG_USED_BITS-1:0] bits);
        cfg_t c;
        c.rv_mode    = bits[RV_MODE_LSB];
        c.wr_count   = bits[WR_COUNT_LSB   +: FIELD_W];
        c.rd_start   = bits[RD_START_LSB   +: FIELD_W];
        c.rd_offset  = bits[RD_OFFSET_LSB  +: FIELD_W];
        c.rd_extent0 = bits[RD_EXTENT0_LSB +: FIELD_W];
        c.rd_stride0 = bits[RD_STRIDE0_LSB +: FIELD_W];
        c.rd_extent1 = bits[RD_EXTENT1_LSB +: FIELD_W];
        c.rd_stride1 = bits[RD_STRIDE1_LSB +: FIELD_W];
        return c;
    endfunction

endpackage

// File: rtl/lake_spec_addr_gen.sv
// Two-level affine read-index generator: idx = offset + i0*stride0 + i1*stride1,
// with i0 as the inner loop; step advances one read, done flags an exhausted pattern.
module lake_spec_addr_gen
    import lake_spec_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        step,
    input  logic [15:0] offset,
    input  logic [15:0] extent0,
    input  logic [15:0] stride0,
    input  logic [15:0] extent1,
    input  logic [15:0] stride1,
    output logic [15:0] idx,
    output logic [15:0] base,
    output logic        last_outer,
    output logic        done
);

    logic [15:0] i0_q, i0_d;
    logic [15:0] i1_q, i1_d;
    logic [16:0] i0_next;
    logic [16:0] i1_next;

    always_comb begin
        i0_next    = {1'b0, i0_q} + 17'd1;
        i1_next    = {1'b0, i1_q} + 17'd1;
        base       = offset + i1_q * stride1;
        idx        = base + i0_q * stride0;
        // A zero extent on either loop means the pattern is empty from the start.
        done       = (extent0 == 16'd0) || (extent1 == 16'd0) || (i1_q >= extent1);
        last_outer = i1_next >= {1'b0, extent1};

        i0_d = i0_q;
        i1_d = i1_q;
        if (flush) begin
            i0_d = '0;
            i1_d = '0;
        end else if (step && !done) begin
            if (i0_next >= {1'b0, extent0}) begin
                i0_d = '0;
                i1_d = i1_next[15:0];
            end else begin
                i0_d = i0_next[15:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i0_q <= '0;
            i1_q <= '0;
        end else begin
            i0_q <= i0_d;
            i1_q <= i1_d;
        end
    end

endmodule

// File: rtl/lake_spec.sv
// Circular-SRAM buffer tile: linear writes on port_0, affine-pattern replay on
// port_1, under a fixed cycle schedule or ready/valid flow control.
module lake_spec
    import lake_spec_pkg::*;
#(
    parameter int DATA_WIDTH         = 16,
    parameter int CONFIG_MEMORY_SIZE = 512,
    parameter int MEM_DEPTH          = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [CONFIG_MEMORY_SIZE-1:0] config_memory,
    // Handshake: a word moves on a port in a cycle where valid and ready are
    // both high at the rising edge; in static mode ready/valid follow the schedule.
    input  logic [DATA_WIDTH-1:0]         port_0,
    input  logic                          port_0_valid,
    output logic                          port_0_ready,
    output logic [DATA_WIDTH-1:0]         port_1,
    output logic                          port_1_valid,
    input  logic                          port_1_ready
);

    localparam int AW = $clog2(MEM_DEPTH);

    cfg_t cfg;
    assign cfg = decode_cfg(config_memory[CFG_USED_BITS-1:0]);

    generate
        if (CONFIG_MEMORY_SIZE > CFG_USED_BITS) begin : g_cfg_unused
            logic cfg_unused;
            assign cfg_unused = ^config_memory[CONFIG_MEMORY_SIZE-1:CFG_USED_BITS];
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic [15:0]           wr_idx_q, wr_idx_d;
    logic [15:0]           cycle_q, cycle_d;
    logic [15:0]           out_idx_q, out_idx_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;

    logic [15:0]   idx, base, next_base, floor_idx;
    logic          last_outer, done;
    logic [16:0]   win_limit;
    logic          win_ok, wr_fire, rd_issue, drain;
    logic [AW-1:0] wr_addr, rd_addr;

    lake_spec_addr_gen u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .step       (rd_issue),
        .offset     (cfg.rd_offset),
        .extent0    (cfg.rd_extent0),
        .stride0    (cfg.rd_stride0),
        .extent1    (cfg.rd_extent1),
        .stride1    (cfg.rd_stride1),
        .idx        (idx),
        .base       (base),
        .last_outer (last_outer),
        .done       (done)
    );

    always_comb begin
        wr_addr   = wr_idx_q[AW-1:0];
        rd_addr   = idx[AW-1:0];
        next_base = base + cfg.rd_stride1;

        // Lowest index the consumer may still need: the word parked in the
        // output register, else the next read, capped by the next outer base.
        floor_idx = out_valid_q ? out_idx_q : idx;
        if (!last_outer && (next_base < floor_idx)) begin
            floor_idx = next_base;
        end
        win_limit = {1'b0, floor_idx} + 17'(MEM_DEPTH);
        win_ok    = (done && !out_valid_q) || ({1'b0, wr_idx_q} < win_limit);

        if (cfg.rv_mode) begin
            port_0_ready = (wr_idx_q < cfg.wr_count) && win_ok;
        end else begin
            port_0_ready = cycle_q < cfg.wr_count;
        end
        port_0_ready = port_0_ready && rst_n && !flush;

        wr_fire = port_0_ready && (port_0_valid || !cfg.rv_mode);
        drain   = out_valid_q && port_1_ready;

        if (cfg.rv_mode) begin
            rd_issue = !flush && !done && (idx < wr_idx_q) && (!out_valid_q || port_1_ready);
        end else begin
            rd_issue = !flush && !done && (cycle_q >= cfg.rd_start);
        end

        wr_idx_d = wr_idx_q;
        cycle_d  = cycle_q;
        if (flush) begin
            wr_idx_d = '0;
            cycle_d  = '0;
        end else begin
            if (wr_fire) begin
                wr_idx_d = wr_idx_q + 16'd1;
            end
            if (cycle_q != 16'hFFFF) begin
                cycle_d = cycle_q + 16'd1;
            end
        end

        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_idx_d   = '0;
            out_data_d  = '0;
            out_valid_d = 1'b0;
        end else if (rd_issue) begin
            out_idx_d   = idx;
            out_data_d  = mem_q[rd_addr];
            out_valid_d = 1'b1;
        end else if (!cfg.rv_mode || drain) begin
            out_valid_d = 1'b0;
        end
    end

    // Storage has no reset; a same-edge write and read of one address returns the old word.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_addr] <= port_0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx_q    <= '0;
            cycle_q     <= '0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wr_idx_q    <= wr_idx_d;
            cycle_q     <= cycle_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign port_1       = out_data_q;
    assign port_1_valid = out_valid_q;

endmodule

// File: tb/tb_lake_spec.sv
// Directed bench for lake_spec: static replay, RV backpressure, reuse,
// slow writer, random consumer stalls and reset mid-stream.
module tb_lake_spec;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic [511:0] config_memory;
    logic [15:0]  port_0;
    logic         port_0_valid;
    logic         port_0_ready;
    logic [15:0]  port_1;
    logic         port_1_valid;
    logic         port_1_ready;

    lake_spec dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .config_memory (config_memory),
        .port_0        (port_0),
        .port_0_valid  (port_0_valid),
        .port_0_ready  (port_0_ready),
        .port_1        (port_1),
        .port_1_valid  (port_1_valid),
        .port_1_ready  (port_1_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    int          cur_cyc = 0;
    int          n_acc = 0;
    int          first_cyc = -1;
    int          last_cyc = -1;
    int          last_rdy_cyc = -1;
    logic        rv_tb = 1'b0;
    logic [15:0] data_base = '0;
    logic        hold_pend = 1'b0;
    logic [15:0] hold_data = '0;
    int          snap_acc = -1;
    int          snap_rdy = -1;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] make_cfg(input logic rv, input logic [15:0] wrc,
        input logic [15:0] st, input logic [15:0] off, input logic [15:0] e0,
        input logic [15:0] s0, input logic [15:0] e1, input logic [15:0] s1);
        logic [511:0] c;
        c = '1;
        c[112:0] = {s1, e1, s0, e0, off, st, wrc, rv};
        return c;
    endfunction

    // Monitor: collects delivered words, counts accepted writes, checks hold stability.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", int'(port_1_valid), 1);
                check("hold_data", int'(port_1), int'(hold_data));
            end
            if (port_0_ready) last_rdy_cyc = cur_cyc;
            if (port_0_valid && port_0_ready) n_acc++;
            if (port_1_valid && (!rv_tb || port_1_ready)) begin
                if (obs_q.size() == 0) first_cyc = cur_cyc;
                last_cyc = cur_cyc;
                obs_q.push_back(port_1);
            end
            hold_pend = rv_tb && port_1_valid && !port_1_ready;
            hold_data = port_1;
        end
    end

    task automatic start(input logic [511:0] c, input logic rv, input logic [15:0] dbase);
        config_memory = c;
        rv_tb         = rv;
        data_base     = dbase;
        flush         = 1'b1;
        port_0_valid  = 1'b0;
        port_1_ready  = 1'b0;
        @(posedge clk);
        #1;
        flush        = 1'b0;
        obs_q.delete();
        n_acc        = 0;
        first_cyc    = -1;
        last_cyc     = -1;
        last_rdy_cyc = -1;
        snap_acc     = -1;
        snap_rdy     = -1;
    endtask

    // rmode: 0 always ready, 1 stalled for 64 cycles, 2 random
    task automatic run_phase(input int max_cyc, input int vperiod, input int rmode, input int stop_acc);
        for (int c = 0; c < max_cyc; c++) begin
            cur_cyc      = c;
            port_0       = 16'(int'(data_base) + 2 * n_acc);
            port_0_valid = ((c % vperiod) == 0);
            case (rmode)
                0:       port_1_ready = 1'b1;
                1:       port_1_ready = (c >= 64);
                default: port_1_ready = 1'($urandom_range(0, 1));
            endcase
            if (rmode == 1 && c == 64) begin
                snap_acc = n_acc;
                snap_rdy = int'(port_0_ready);
            end
            @(posedge clk);
            #1;
            if (stop_acc > 0 && n_acc >= stop_acc) break;
        end
        port_0_valid = 1'b0;
    endtask

    task automatic compare_seq(input string tag);
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("%s_w%0d", tag, i), int'(obs_q[i]), int'(exp_q[i]));
        end
        exp_q.delete();
    endtask

    logic [15:0] pat_idx [10];

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        config_memory = '0;
        port_0        = '0;
        port_0_valid  = 1'b0;
        port_1_ready  = 1'b0;
        pat_idx       = '{16'd0, 16'd2, 16'd4, 16'd6, 16'd8, 16'd1, 16'd3, 16'd5, 16'd7, 16'd9};

        repeat (3) @(posedge clk);
        #1;
        check("rst_p0_ready", int'(port_0_ready), 0);
        check("rst_p1_valid", int'(port_1_valid), 0);
        check("rst_p1_data", int'(port_1), 0);
        rst_n = 1'b1;

        // Static pass-through: writes 0..15, reads issued from cycle 4
        start(make_cfg(1'b0, 16'd16, 16'd4, 16'd0, 16'd16, 16'd1, 16'd1, 16'd0), 1'b0, 16'd0);
        run_phase(40, 1, 0, 0);
        for (int i = 0; i < 16; i++) exp_q.push_back(16'(2 * i));
        compare_seq("static");
        check("static_first_cyc", first_cyc, 5);
        check("static_last_cyc", last_cyc, 20);
        check("static_writes", n_acc, 16);
        check("static_last_ready", last_rdy_cyc, 15);

        // RV backpressure: consumer stalled for 64 cycles
        start(make_cfg(1'b1, 16'd100, 16'd0, 16'd0, 16'd100, 16'd1, 16'd1, 16'd0), 1'b1, 16'd0);
        run_phase(250, 1, 1, 0);
        check("bp_writes_at_stall", snap_acc, 64);
        check("bp_ready_at_stall", snap_rdy, 0);
        check("bp_total_writes", n_acc, 100);
        for (int i = 0; i < 100; i++) exp_q.push_back(16'(2 * i));
        compare_seq("bp");
        check("bp_end_ready", int'(port_0_ready), 0);
        check("bp_end_valid", int'(port_1_valid), 0);

        // Reuse: 4 words replayed 3 times
        start(make_cfg(1'b1, 16'd4, 16'd0, 16'd0, 16'd4, 16'd1, 16'd3, 16'd0), 1'b1, 16'd500);
        run_phase(40, 1, 0, 0);
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < 4; i++) exp_q.push_back(16'(500 + 2 * i));
        compare_seq("reuse");
        check("reuse_writes", n_acc, 4);

        // 2-level pattern at full rate, then with a writer valid every 4th cycle
        start(make_cfg(1'b1, 16'd20, 16'd0, 16'd0, 16'd5, 16'd2, 16'd2, 16'd1), 1'b1, 16'd1000);
        run_phase(60, 1, 0, 0);
        for (int i = 0; i < 10; i++) exp_q.push_back(16'(1000 + 2 * int'(pat_idx[i])));
        compare_seq("pat_full");

        start(make_cfg(1'b1, 16'd20, 16'd0, 16'd0, 16'd5, 16'd2, 16'd2, 16'd1), 1'b1, 16'd2000);
        run_phase(120, 4, 0, 0);
        for (int i = 0; i < 10; i++) exp_q.push_back(16'(2000 + 2 * int'(pat_idx[i])));
        compare_seq("pat_slow");
        check("pat_slow_writes", n_acc, 20);

        // Random consumer stalls
        start(make_cfg(1'b1, 16'd20, 16'd0, 16'd0, 16'd5, 16'd2, 16'd2, 16'd1), 1'b1, 16'd3000);
        run_phase(120, 1, 2, 0);
        for (int i = 0; i < 10; i++) exp_q.push_back(16'(3000 + 2 * int'(pat_idx[i])));
        compare_seq("stall");

        // Reset after 10 writes, then flush and rerun the backpressure config at full rate
        start(make_cfg(1'b1, 16'd100, 16'd0, 16'd0, 16'd100, 16'd1, 16'd1, 16'd0), 1'b1, 16'd0);
        run_phase(50, 1, 0, 10);
        check("mid_writes_before_rst", n_acc, 10);
        rst_n = 1'b0;
        #1;
        check("mid_rst_p0_ready", int'(port_0_ready), 0);
        check("mid_rst_p1_valid", int'(port_1_valid), 0);
        check("mid_rst_p1_data", int'(port_1), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start(make_cfg(1'b1, 16'd100, 16'd0, 16'd0, 16'd100, 16'd1, 16'd1, 16'd0), 1'b1, 16'd0);
        run_phase(250, 1, 0, 0);
        for (int i = 0; i < 100; i++) exp_q.push_back(16'(2 * i));
        compare_seq("rerun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
